pir_stim_gen: RTL
=================

Name: pir_stim_gen

Overview:
- Synthesisable, parametrised N-channel PIR stimulus sequencer for the motion-detection datapath. It is used for on-chip self-test and for benches.
- Generalises the fixed sensor/turn/stop_alarm stimulus pattern. Channel count, counter width, per-channel delay and pulse width, period and loop count are all programmable.
- Runs on repeat, supports abort, and produces a completion handshake.
- Drives the pir_sensor inputs, turn and stop_alarm of the motion-detection controller.

Parameters:
- N_CH, 3, number of PIR channels
- CNT_W, 16, width of the time counter, delays, widths and period
- LOOP_W, 8, width of the loop count
- STOP_LEN, 2, number of cycles stop_alarm is held high at end of sequence (minimum 1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse: latch config and begin sequence (accepted only in IDLE)
- abort  in  1  terminate the running sequence immediately
- cfg_delay  in  N_CH*CNT_W  per-channel assert offset; channel i occupies bits [i*CNT_W +: CNT_W]
- cfg_width  in  N_CH*CNT_W  per-channel pulse width; 0 = channel never asserts
- cfg_period  in  CNT_W  sequence length in cycles; 0 is illegal
- cfg_loops  in  LOOP_W  number of repetitions; 0 = infinite until abort
- pir_sensor  out  N_CH  generated sensor levels
- turn  out  1  system-enable level; high throughout RUN
- stop_alarm  out  1  high for STOP_LEN cycles after normal completion
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse in the first DONE cycle
- cfg_err  out  1  one-cycle pulse when start is rejected because cfg_period==0

Behaviour:
- Reset (rst_n low at a rising edge) forces the following, regardless of state:
  - state = IDLE; counter t = 0; loop counter = 0
  - all outputs 0, including mid-sequence
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and cfg_period!=0 → latch all cfg_* inputs, go to RUN with t=0 and loop count=1.
  - start=1 and cfg_period==0 → cfg_err=1 for one cycle, stay in IDLE.
- RUN:
  - t increments by 1 each cycle.
  - At t==period-1: t wraps to 0.
    - If loops!=0 and loop count==loops → go to DONE.
    - Otherwise loop count increments (saturates at its maximum value when loops==0).
  - abort=1 → IDLE next cycle. All outputs 0; no done and no stop_alarm.
  - abort wins over a simultaneous wrap or end of sequence.
- DONE:
  - stop_alarm=1 for exactly STOP_LEN cycles; done=1 in the first of them only.
  - Then go to IDLE.
  - abort is ignored.
- start while busy is ignored. Config changes while busy have no effect; the latched copy is used.
- Outputs are registered and aligned to t:
  - In the RUN cycle whose counter value is T, pir_sensor[i] = (T >= delay_i) && (T < delay_i + width_i).
  - The sum delay_i + width_i is computed in CNT_W+1 bits, so there is no wrap; a pulse is truncated at the period end.
  - delay_i >= period → channel never asserts.
- turn=1 in every RUN cycle, 0 otherwise. busy = RUN or DONE.
- Latency: start sampled at edge k → first RUN cycle (t=0) begins at edge k+1, with turn and any delay-0 channel already high.
- pir_sensor = 0 in IDLE and DONE.

Optional Feature:
- Macro: PIR_STIM_JITTER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 at reset, advances once per loop wrap.
  - Every channel's effective delay in a loop = latched delay + lfsr[1:0], computed in CNT_W+1 bits. The offset for loop 1 is the seed's bits [1:0].
  - Models sensor skew.
- Not defined: no LFSR logic; offset is 0.

Decomposition:
- Package pir_stim_pkg:
  - state enum {IDLE, RUN, DONE}
  - default widths
  - LFSR seed and tap constants
- Sub-module pir_chan_window (one instance per channel, via generate): inputs t, delay, width; registered output pir level.
- The FSM, counters and LFSR live in the top.

Test Plan:
- N_CH=3, period=10, loops=1, delay={0,2,5}, width={3,4,0}, start at edge 0 →
  - pir[0] high in cycles 1–3; pir[1] high in cycles 3–6; pir[2] never high
  - turn high in cycles 1–10
  - done in cycle 11; stop_alarm high in cycles 11–12; busy low from cycle 13
- Same config with loops=3 → pir[0] pulses start at cycles 1, 11 and 21; done in cycle 31.
- loops=0 with abort asserted at cycle 25 → all outputs 0 from cycle 26; done and stop_alarm never assert.
- cfg_period=0 with start → cfg_err pulses once, busy stays 0; a second start during RUN is ignored and the counter is unperturbed.
- delay=8, width=5, period=10 → pir high at t=8 and 9 only. Reset asserted mid-RUN → all outputs 0 the next cycle, state is IDLE.
- With PIR_STIM_JITTER_EN defined:
  - loop 1 offset = 1 (seed 16'hACE1, bits[1:0]=01), so delay 0 → pir first high at t=1
  - later offsets match a reference-model LFSR

Source files
------------

// File: rtl/pir_stim_pkg.sv
// -----------------------------------------------------------------------------
// pir_stim_pkg
// Shared types and constants for the PIR stimulus sequencer.
//   - state_t      : sequencer FSM states
//   - *_DEF        : default parameter values for the sequencer and channels
//   - LFSR_SEED    : reset/start seed of the jitter LFSR
//   - LFSR_TAP_MSK : feedback taps (16,14,13,11) in right-shifting form
//   - lfsr_step()  : one advance of the Fibonacci LFSR
// -----------------------------------------------------------------------------
package pir_stim_pkg;

  localparam int N_CH_DEF     = 3;
  localparam int CNT_W_DEF    = 16;
  localparam int LOOP_W_DEF   = 8;
  localparam int STOP_LEN_DEF = 2;

  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // Taps 16,14,13,11 map to bits 0,2,3,5 when the register shifts right.
  localparam logic [15:0] LFSR_TAP_MSK = 16'h002D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {^(l & LFSR_TAP_MSK), l[15:1]};
  endfunction

endpackage

// File: rtl/pir_chan_window.sv
// -----------------------------------------------------------------------------
// pir_chan_window
// One PIR channel: registers a level that is high while the time value lies in
// the window [delay, delay + width). The end is computed wide enough that it
// never wraps, so a pulse is simply cut off when t stops short of the end.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_en       : window may assert (sequencer is in RUN next cycle)
//   i_t        : time value of the upcoming cycle
//   i_delay    : effective start offset (CNT_W+1 bits, includes any jitter)
//   i_width    : pulse width; 0 never asserts
//   o_pir      : registered sensor level
// -----------------------------------------------------------------------------
module pir_chan_window
  import pir_stim_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_t,
  input  logic [CNT_W:0]   i_delay,
  input  logic [CNT_W-1:0] i_width,
  output logic             o_pir
);

  logic [CNT_W+1:0] w_end;
  logic             w_hit;

  assign w_end = {1'b0, i_delay} + {2'b00, i_width};
  assign w_hit = ({1'b0, i_t} >= i_delay) && ({2'b00, i_t} < w_end);

  always_ff @(posedge clk) begin
    if (!rst_n) o_pir <= 1'b0;
    else        o_pir <= i_en && w_hit;
  end

endmodule

// File: rtl/pir_stim_gen.sv
// -----------------------------------------------------------------------------
// pir_stim_gen
// N-channel PIR stimulus sequencer for the motion-detection datapath. Plays a
// programmable sensor pattern for cfg_loops repetitions of cfg_period cycles,
// then holds stop_alarm for STOP_LEN cycles and pulses done.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : latch cfg_* and begin (IDLE only)
//   abort                 : end a running sequence at once (ignored in DONE)
//   cfg_delay, cfg_width  : per-channel offset / width, channel i at [i*CNT_W +: CNT_W]
//   cfg_period            : sequence length (0 rejected with cfg_err)
//   cfg_loops             : repetitions, 0 = until abort
//   pir_sensor, turn      : generated sensor levels, system enable (RUN)
//   stop_alarm, done      : end-of-sequence level / first-cycle pulse
//   busy, cfg_err         : not IDLE / rejected start pulse
// Optional feature: define PIR_STIM_JITTER_EN to add a per-loop 0..3 cycle
// skew to every channel delay, taken from a 16-bit LFSR.
// All outputs are registered from the next-state values, so they line up with
// the counter value of the cycle they belong to.
// -----------------------------------------------------------------------------
module pir_stim_gen
  import pir_stim_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOOP_W   = LOOP_W_DEF,
  parameter int STOP_LEN = STOP_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N_CH*CNT_W-1:0] cfg_delay,
  input  logic [N_CH*CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0]      cfg_period,
  input  logic [LOOP_W-1:0]     cfg_loops,
  output logic [N_CH-1:0]       pir_sensor,
  output logic                  turn,
  output logic                  stop_alarm,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int DCNT_W = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_t, w_t_nx;
  logic [LOOP_W-1:0]   r_loop, w_loop_nx;
  logic [DCNT_W-1:0]   r_dcnt, w_dcnt_nx;
  logic                w_start_ok, w_cfg_err, w_wrap, w_end_seq;
  logic [1:0]          w_off;

  logic [N_CH*CNT_W-1:0] r_delay, r_width;
  logic [CNT_W-1:0]      r_period;
  logic [LOOP_W-1:0]     r_loops;

  logic r_turn, r_stop, r_busy, r_done, r_cfg_err;

  assign w_wrap    = (r_t == r_period - CNT_W'(1));
  assign w_end_seq = (r_loops != '0) && (r_loop == r_loops);

  always_comb begin
    w_state_nx = r_state;
    w_t_nx     = r_t;
    w_loop_nx  = r_loop;
    w_dcnt_nx  = r_dcnt;
    w_start_ok = 1'b0;
    w_cfg_err  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (cfg_period != '0) begin
            w_start_ok = 1'b1;
            w_state_nx = RUN;
            w_t_nx     = '0;
            w_loop_nx  = LOOP_W'(1);
          end else begin
            w_cfg_err = 1'b1;
          end
        end
      end
      RUN: begin
        // abort takes priority over wrap and end of sequence
        if (abort) begin
          w_state_nx = IDLE;
          w_t_nx     = '0;
          w_loop_nx  = '0;
        end else if (w_wrap) begin
          w_t_nx = '0;
          if (w_end_seq) begin
            w_state_nx = DONE;
            w_dcnt_nx  = '0;
          end else if (r_loop != {LOOP_W{1'b1}}) begin
            w_loop_nx = r_loop + LOOP_W'(1);
          end
        end else begin
          w_t_nx = r_t + CNT_W'(1);
        end
      end
      DONE: begin
        if (r_dcnt == DCNT_W'(STOP_LEN - 1)) begin
          w_state_nx = IDLE;
          w_loop_nx  = '0;
        end else begin
          w_dcnt_nx = r_dcnt + DCNT_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_t       <= '0;
      r_loop    <= '0;
      r_dcnt    <= '0;
      r_turn    <= 1'b0;
      r_stop    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_t       <= w_t_nx;
      r_loop    <= w_loop_nx;
      r_dcnt    <= w_dcnt_nx;
      r_turn    <= (w_state_nx == RUN);
      r_stop    <= (w_state_nx == DONE);
      r_busy    <= (w_state_nx != IDLE);
      r_done    <= (r_state == RUN) && (w_state_nx == DONE);
      r_cfg_err <= w_cfg_err;
    end
  end

  // Configuration snapshot; data only, so no reset.
  always_ff @(posedge clk) begin
    if (w_start_ok) begin
      r_delay  <= cfg_delay;
      r_width  <= cfg_width;
      r_period <= cfg_period;
      r_loops  <= cfg_loops;
    end
  end

`ifdef PIR_STIM_JITTER_EN
  logic [15:0] r_lfsr, w_lfsr_nx;

  // Reseeded on every accepted start so loop 1 always uses the seed's offset.
  always_comb begin
    w_lfsr_nx = r_lfsr;
    if (w_start_ok)
      w_lfsr_nx = LFSR_SEED;
    else if ((r_state == RUN) && !abort && w_wrap)
      w_lfsr_nx = lfsr_step(r_lfsr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= w_lfsr_nx;
  end

  assign w_off = w_lfsr_nx[1:0];
`else
  assign w_off = 2'b00;
`endif

  // Windows see the upcoming cycle's t and config; on the start edge the
  // snapshot is not loaded yet, so the live inputs are used instead.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] w_dly, w_wid;
    logic [CNT_W:0]   w_eff;

    assign w_dly = w_start_ok ? cfg_delay[g*CNT_W +: CNT_W] : r_delay[g*CNT_W +: CNT_W];
    assign w_wid = w_start_ok ? cfg_width[g*CNT_W +: CNT_W] : r_width[g*CNT_W +: CNT_W];
    assign w_eff = {1'b0, w_dly} + {{(CNT_W-1){1'b0}}, w_off};

    pir_chan_window #(
      .CNT_W (CNT_W)
    ) u_win (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_state_nx == RUN),
      .i_t     (w_t_nx),
      .i_delay (w_eff),
      .i_width (w_wid),
      .o_pir   (pir_sensor[g])
    );
  end

  assign turn       = r_turn;
  assign stop_alarm = r_stop;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cfg_err    = r_cfg_err;

endmodule
